// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern transmitter with repeat count and idle-high gap
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP_WAIT} state_t;

    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             sout_d, valid_d, busy_d, done_d;
    logic [LEN_W-1:0] eff_len;

    // Shift instead of a variable bit-select so the index width need not match WIDTH.
    function automatic logic pick(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
        logic [WIDTH-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            rep_q      <= '0;
            gap_q      <= '0;
            sout       <= 1'b1;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            rep_q      <= rep_d;
            gap_q      <= gap_d;
            sout       <= sout_d;
            sout_valid <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next-state logic computes the values the outputs will carry in the following cycle.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        sout_d  = 1'b1;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        eff_len = (len > WIDTH_L) ? WIDTH_L : len;

        case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d = SHIFT;
                    pat_d   = pattern;
                    len_d   = eff_len;
                    rep_d   = (reps == '0) ? ONE_C : reps;
                    idx_d   = eff_len - ONE_L;
                    sout_d  = pick(pattern, eff_len - ONE_L);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (idx_q != '0) begin
                    idx_d   = idx_q - ONE_L;
                    sout_d  = pick(pat_q, idx_q - ONE_L);
                    valid_d = 1'b1;
                end else if (rep_q > ONE_C) begin
                    rep_d = rep_q - ONE_C;
                    if (GAP > 0) begin
                        state_d = GAP_WAIT;
                        gap_d   = GAP_LAST;
                    end else begin
                        idx_d   = len_q - ONE_L;
                        sout_d  = pick(pat_q, len_q - ONE_L);
                        valid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            GAP_WAIT: begin
                busy_d = 1'b1;
                if (gap_q == '0) begin
                    state_d = SHIFT;
                    idx_d   = len_q - ONE_L;
                    sout_d  = pick(pat_q, len_q - ONE_L);
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                rep_d   = '0;
                gap_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - directed self-checking bench for serial_pattern_tx
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic       sout, sout_valid, busy, done;

    int checks = 0;
    int failures = 0;

    logic [15:0] v_sout, v_valid, v_busy, v_done, v_det;
    logic [2:0]  hist;

    serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
        .sout(sout), .sout_valid(sout_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_vecs();
        v_sout = '0; v_valid = '0; v_busy = '0; v_done = '0; v_det = '0; hist = '0;
    endtask

    // Record n cycles; first recorded cycle ends up as the most significant bit.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            v_sout  = {v_sout[14:0], sout};
            v_valid = {v_valid[14:0], sout_valid};
            v_busy  = {v_busy[14:0], busy};
            v_done  = {v_done[14:0], done};
            if (sout_valid) begin
                hist  = {hist[1:0], sout};
                v_det = {v_det[14:0], (hist == 3'b100)};
            end
        end
    endtask

    task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        pattern = p; len = l; reps = r; start = 1'b1;
        clear_vecs();
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pattern = 8'hFF; len = 4'd4; reps = 4'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({sout, sout_valid, busy, done} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got %b expected 1000", i, {sout, sout_valid, busy, done});
            end
        end
        rst = 1'b0; start = 1'b0;
        tick();
        launch(8'h09, 4'd4, 4'd1);
        capture(2);
        rst = 1'b1;
        tick();
        checks++;
        if ({sout, sout_valid, busy, done} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_mid: got %b expected 1000", {sout, sout_valid, busy, done});
        end
        rst = 1'b0;
        clear_vecs();
        capture(6);
        cmp("reset_mid_no_done", v_done, 16'h0000);
        cmp("reset_mid_no_busy", v_busy, 16'h0000);
    endtask

    task automatic test_basic();
        launch(8'h09, 4'd4, 4'd1);
        capture(6);
        cmp("basic_sout",  v_sout,  16'b100111);
        cmp("basic_valid", v_valid, 16'b111100);
        cmp("basic_busy",  v_busy,  16'b111100);
        cmp("basic_done",  v_done,  16'b000010);
    endtask

    task automatic test_gap();
        launch(8'b11, 4'd2, 4'd3);
        capture(12);
        cmp("gap_sout",  v_sout,  16'b111111111111);
        cmp("gap_valid", v_valid, 16'b110011001100);
        cmp("gap_busy",  v_busy,  16'b111111111100);
        cmp("gap_done",  v_done,  16'b000000000010);
    endtask

    task automatic test_edges();
        launch(8'hA5, 4'd3, 4'd0);
        capture(5);
        cmp("reps0_sout",  v_sout,  16'b10111);
        cmp("reps0_valid", v_valid, 16'b11100);
        cmp("reps0_done",  v_done,  16'b00010);
        launch(8'hFF, 4'd0, 4'd2);
        capture(4);
        cmp("len0_busy",  v_busy,  16'h0000);
        cmp("len0_valid", v_valid, 16'h0000);
        cmp("len0_done",  v_done,  16'h0000);
        launch(8'h96, 4'd15, 4'd1);
        capture(10);
        cmp("len15_sout",  v_sout,  16'b1001011011);
        cmp("len15_valid", v_valid, 16'b1111111100);
        cmp("len15_done",  v_done,  16'b0000000010);
    endtask

    task automatic test_back_to_back();
        launch(8'h0D, 4'd4, 4'd1);
        for (int i = 0; i < 9; i++) begin
            capture(1);
            if (i < 4) begin
                pattern = 8'h30 + 8'(i * 17); len = 4'd8; start = 1'b1;
            end else if (i == 4) begin
                pattern = 8'h02; len = 4'd2; start = 1'b1;
            end else begin
                pattern = 8'hFF; len = 4'd8; start = 1'b0;
            end
        end
        start = 1'b0;
        cmp("b2b_sout",  v_sout,  16'b110111011);
        cmp("b2b_valid", v_valid, 16'b111101100);
        cmp("b2b_busy",  v_busy,  16'b111101100);
        cmp("b2b_done",  v_done,  16'b000010010);
    endtask

    task automatic test_closed_loop();
        launch(8'b1100_1000, 4'd8, 4'd1);
        capture(10);
        cmp("loop_sout", v_sout,  16'b1100100011);
        cmp("loop_det",  v_det,   16'b00010010);
        cmp("loop_done", v_done,  16'b0000000010);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0;
        clear_vecs();
        tick();
        test_reset();
        test_basic();
        test_gap();
        test_edges();
        test_back_to_back();
        test_closed_loop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
